// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle scheduler and the level state machine.
// Spawn periods are indexed by phase kind; tick boundaries mark the level phase changes.
package obstacle_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StWaitSlot,
        StIssue
    } sched_state_t;

    localparam logic [2:0] KIND_NONE = 3'd7;

    localparam int unsigned SPAWN_PERIOD [7] = '{40, 35, 30, 25, 20, 15, 10};

    localparam int unsigned TICK_BOUNDARY [7] = '{130, 260, 390, 520, 650, 780, 910};
    localparam int unsigned LEVEL_END_TICK = 1300;

    // Lowest set bit of the one-hot phase vector; KIND_NONE when no phase is active.
    function automatic logic [2:0] kind_of(input logic [6:0] shapes);
        logic [2:0] k;
        k = KIND_NONE;
        for (int i = 6; i >= 0; i--) begin
            if (shapes[i]) k = 3'(i);
        end
        return k;
    endfunction

    function automatic logic [2:0] lowest_zero(input logic [7:0] v);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!v[i]) s = 3'(i);
        end
        return s;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/obstacle_scheduler_if.sv
// Spawn handshake between the scheduler (master) and the obstacle datapath (slave),
// plus the per-slot release pulses coming back from the datapath.
interface obstacle_scheduler_if #(
    parameter int unsigned NSLOT = 4
);
    logic             spawn_valid;
    logic             spawn_ready;
    logic [2:0]       spawn_kind;
    logic [2:0]       spawn_slot;
    logic [NSLOT-1:0] slot_free;

    modport master (
        output spawn_valid,
        output spawn_kind,
        output spawn_slot,
        input  spawn_ready,
        input  slot_free
    );

    modport slave (
        input  spawn_valid,
        input  spawn_kind,
        input  spawn_slot,
        output spawn_ready,
        output slot_free
    );
endinterface

// File: rtl/tick_sync.sv
// Brings the asynchronous slow game clock into the clk domain and emits a
// single-cycle tick on each of its rising edges.
module tick_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic tick
);
    logic s1, s2, s3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick = s2 & ~s3;
endmodule

// File: rtl/obstacle_scheduler.sv
// Level clock and obstacle spawn scheduler: counts game ticks, raises one spawn per
// phase period, and allocates obstacle slots from a fixed pool.
module obstacle_scheduler
    import obstacle_pkg::*;
#(
    parameter int unsigned NSLOT = 4,
    parameter int unsigned TW    = 11,
    parameter int unsigned PW    = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       slowClk,
    input  logic                       run,
    input  logic                       playerDied,
    input  logic [6:0]                 shapes,
    obstacle_scheduler_if.master       spawn_bus,
    output logic [TW-1:0]              game_time,
    output logic [3:0]                 active_count,
    output logic [7:0]                 drop_cnt
);
    logic tick;

    tick_sync u_tick_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (slowClk),
        .tick     (tick)
    );

    sched_state_t     state;
    logic [PW-1:0]    period_cnt;
    logic [NSLOT-1:0] busy;
    logic [2:0]       kind_q;
    logic             spawn_valid_q;
    logic [2:0]       spawn_kind_q;
    logic [2:0]       spawn_slot_q;

    logic [2:0]       kind;
    logic             kind_valid;
    logic             kind_change;
    logic [PW-1:0]    period_last;
    logic             period_hit;
    logic [PW-1:0]    period_cnt_next;
    logic [TW-1:0]    game_time_next;
    logic [NSLOT-1:0] busy_freed;
    logic [NSLOT-1:0] busy_next;
    logic             any_freed;
    logic [7:0]       busy_pad;
    logic [7:0]       busy_next_pad;
    logic             slot_avail;
    logic [2:0]       free_slot;
    logic             alloc;

    always_comb begin
        kind        = kind_of(shapes);
        kind_valid  = (kind != KIND_NONE);
        kind_change = (kind != kind_q);
        period_last = kind_valid ? PW'(SPAWN_PERIOD[kind] - 1) : '1;
        period_hit  = tick && kind_valid && !kind_change && (period_cnt == period_last);

        // A phase boundary restarts the period so the new rate applies from its start.
        if (kind_change) begin
            period_cnt_next = '0;
        end else if (tick && kind_valid) begin
            period_cnt_next = period_hit ? '0 : period_cnt + 1'b1;
        end else begin
            period_cnt_next = period_cnt;
        end

        game_time_next = (tick && game_time != '1) ? game_time + 1'b1 : game_time;

        busy_freed = busy & ~spawn_bus.slot_free;
        any_freed  = |(busy & spawn_bus.slot_free);

        // Unused upper slots read as busy so they are never granted.
        busy_pad               = '1;
        busy_pad[NSLOT-1:0]    = busy_freed;
        slot_avail             = ~&busy_pad;
        free_slot              = lowest_zero(busy_pad);

        alloc = (state == StIssue) && spawn_valid_q && spawn_bus.spawn_ready &&
                run && !playerDied;
        busy_next = busy_freed | (alloc ? (NSLOT'(1) << spawn_slot_q) : '0);

        busy_next_pad            = '0;
        busy_next_pad[NSLOT-1:0] = busy_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= StIdle;
            game_time     <= '0;
            period_cnt    <= '0;
            busy          <= '0;
            active_count  <= '0;
            drop_cnt      <= '0;
            kind_q        <= KIND_NONE;
            spawn_valid_q <= 1'b0;
            spawn_kind_q  <= 3'd0;
            spawn_slot_q  <= 3'd0;
        end else begin
            kind_q       <= kind;
            busy         <= busy_next;
            active_count <= popcount8(busy_next_pad);

            if (playerDied) begin
                state         <= run ? StRun : StIdle;
                game_time     <= '0;
                period_cnt    <= '0;
                busy          <= '0;
                active_count  <= '0;
                spawn_valid_q <= 1'b0;
            end else if (state != StIdle && !run) begin
                // Leaving the level abandons any outstanding spawn without counting a drop.
                state         <= StIdle;
                spawn_valid_q <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (run) begin
                            state        <= StRun;
                            game_time    <= '0;
                            period_cnt   <= '0;
                            busy         <= '0;
                            active_count <= '0;
                        end
                    end
                    StRun: begin
                        game_time  <= game_time_next;
                        period_cnt <= period_cnt_next;
                        if (period_hit) begin
                            spawn_kind_q <= kind;
                            if (slot_avail) begin
                                state         <= StIssue;
                                spawn_valid_q <= 1'b1;
                                spawn_slot_q  <= free_slot;
                            end else begin
                                state <= StWaitSlot;
                            end
                        end
                    end
                    StWaitSlot: begin
                        game_time  <= game_time_next;
                        period_cnt <= period_cnt_next;
                        if (period_hit && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                        if (any_freed) begin
                            state         <= StIssue;
                            spawn_valid_q <= 1'b1;
                            spawn_slot_q  <= free_slot;
                        end
                    end
                    StIssue: begin
                        game_time  <= game_time_next;
                        period_cnt <= period_cnt_next;
                        if (period_hit && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                        if (spawn_valid_q && spawn_bus.spawn_ready) begin
                            state         <= StRun;
                            spawn_valid_q <= 1'b0;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    assign spawn_bus.spawn_valid = spawn_valid_q;
    assign spawn_bus.spawn_kind  = spawn_kind_q;
    assign spawn_bus.spawn_slot  = spawn_slot_q;
endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: a vector table for phase/kind decoding plus
// hand-written sequences for slot exhaustion, handshake stall, death, exit and reset.
module tb_obstacle_scheduler;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        slowClk = 1'b0;
    logic        run = 1'b0;
    logic        playerDied = 1'b0;
    logic [6:0]  shapes = 7'd0;
    logic [10:0] game_time;
    logic [3:0]  active_count;
    logic [7:0]  drop_cnt;

    obstacle_scheduler_if #(.NSLOT(4)) bus ();

    obstacle_scheduler #(
        .NSLOT (4),
        .TW    (11),
        .PW    (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .slowClk      (slowClk),
        .run          (run),
        .playerDied   (playerDied),
        .shapes       (shapes),
        .spawn_bus    (bus),
        .game_time    (game_time),
        .active_count (active_count),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    int          hs_count = 0;
    logic [2:0]  hs_kind = 3'd0;
    logic [2:0]  hs_slot = 3'd0;
    logic [10:0] hs_time = 11'd0;

    always @(posedge clk) begin
        if (bus.spawn_valid && bus.spawn_ready) begin
            hs_count = hs_count + 1;
            hs_kind  = bus.spawn_kind;
            hs_slot  = bus.spawn_slot;
            hs_time  = game_time;
        end
    end

    typedef struct {
        logic [6:0]  shapes;
        int          ticks;
        logic [10:0] exp_time;
        logic        exp_valid;
        logic [2:0]  exp_kind;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            slowClk = 1'b1;
            repeat (4) @(negedge clk);
            slowClk = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic start_level(input logic [6:0] sh, input logic rdy);
        @(negedge clk);
        reset_n         = 1'b0;
        shapes          = sh;
        run             = 1'b1;
        playerDied      = 1'b0;
        bus.spawn_ready = rdy;
        bus.slot_free   = 4'd0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int hs0;
        int waited;

        vecs[0] = '{7'b0000100, 30, 11'd30, 1'b1, 3'd2};
        vecs[1] = '{7'b1000000, 10, 11'd10, 1'b1, 3'd6};
        vecs[2] = '{7'b0110000, 20, 11'd20, 1'b1, 3'd4};
        vecs[3] = '{7'b0010000, 19, 11'd19, 1'b0, 3'd0};
        vecs[4] = '{7'b0000000, 20, 11'd20, 1'b0, 3'd0};
        vecs[5] = '{7'b0001000, 25, 11'd25, 1'b1, 3'd3};
        vecs[6] = '{7'b1111111, 40, 11'd40, 1'b1, 3'd0};

        bus.spawn_ready = 1'b0;
        bus.slot_free   = 4'd0;
        repeat (3) @(negedge clk);
        check("reset game_time", 32'(game_time), 0);
        check("reset spawn_valid", 32'(bus.spawn_valid), 0);
        check("reset active_count", 32'(active_count), 0);
        check("reset drop_cnt", 32'(drop_cnt), 0);

        // Single phase 0 spawn on the 40th tick
        start_level(7'b0000001, 1'b1);
        hs0 = hs_count;
        do_ticks(45);
        check("t1 game_time", 32'(game_time), 45);
        check("t1 spawn count", 32'(hs_count - hs0), 1);
        check("t1 spawn kind", 32'(hs_kind), 0);
        check("t1 spawn slot", 32'(hs_slot), 0);
        check("t1 spawn time", 32'(hs_time), 40);
        check("t1 active_count", 32'(active_count), 1);

        for (int v = 0; v < 7; v++) begin
            start_level(vecs[v].shapes, 1'b0);
            do_ticks(vecs[v].ticks);
            check($sformatf("vec%0d game_time", v), 32'(game_time), 32'(vecs[v].exp_time));
            check($sformatf("vec%0d valid", v), 32'(bus.spawn_valid), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d kind", v), 32'(bus.spawn_kind), 32'(vecs[v].exp_kind));
            check($sformatf("vec%0d slot", v), 32'(bus.spawn_slot), 0);
        end

        // Pool exhaustion: wait, drop, then release slot 2
        start_level(7'b0000010, 1'b1);
        hs0 = hs_count;
        do_ticks(140);
        check("t2 spawns", 32'(hs_count - hs0), 4);
        check("t2 active full", 32'(active_count), 4);
        do_ticks(35);
        check("t2 waiting valid", 32'(bus.spawn_valid), 0);
        check("t2 waiting drop", 32'(drop_cnt), 0);
        do_ticks(35);
        check("t2 drop_cnt", 32'(drop_cnt), 1);
        check("t2 game_time", 32'(game_time), 210);
        check("t2 valid still low", 32'(bus.spawn_valid), 0);
        bus.spawn_ready = 1'b0;
        bus.slot_free   = 4'b0100;
        @(negedge clk);
        bus.slot_free = 4'b0000;
        waited = 0;
        while (!bus.spawn_valid && waited < 2) begin
            @(negedge clk);
            waited++;
        end
        check("t2 reissue valid", 32'(bus.spawn_valid), 1);
        check("t2 reissue slot", 32'(bus.spawn_slot), 2);
        check("t2 reissue kind", 32'(bus.spawn_kind), 1);
        check("t2 active after free", 32'(active_count), 3);
        bus.spawn_ready = 1'b1;
        @(negedge clk);
        check("t2 accept valid", 32'(bus.spawn_valid), 0);
        check("t2 accept active", 32'(active_count), 4);

        // Stalled handshake holds its payload
        start_level(7'b1000000, 1'b0);
        do_ticks(10);
        for (int c = 0; c < 10; c++) begin
            check($sformatf("t3 hold clk%0d", c),
                  32'({bus.spawn_valid, bus.spawn_kind, bus.spawn_slot}), 32'({1'b1, 3'd6, 3'd0}));
            @(negedge clk);
        end
        bus.spawn_ready = 1'b1;
        @(negedge clk);
        check("t3 valid after ready", 32'(bus.spawn_valid), 0);
        check("t3 active after ready", 32'(active_count), 1);

        // playerDied during an outstanding spawn at game_time 300
        start_level(7'b0000100, 1'b1);
        do_ticks(30);
        bus.spawn_ready = 1'b0;
        do_ticks(270);
        check("t4 game_time", 32'(game_time), 300);
        check("t4 valid", 32'(bus.spawn_valid), 1);
        check("t4 slot", 32'(bus.spawn_slot), 1);
        check("t4 active", 32'(active_count), 1);
        check("t4 drops", 32'(drop_cnt), 8);
        playerDied = 1'b1;
        @(negedge clk);
        playerDied = 1'b0;
        check("t4 died game_time", 32'(game_time), 0);
        check("t4 died valid", 32'(bus.spawn_valid), 0);
        check("t4 died active", 32'(active_count), 0);
        check("t4 died drop kept", 32'(drop_cnt), 8);
        do_ticks(3);
        check("t4 running after death", 32'(game_time), 3);

        // Leaving and re-entering the level
        run = 1'b0;
        repeat (2) @(negedge clk);
        do_ticks(5);
        check("t5 idle frozen", 32'(game_time), 3);
        check("t5 idle valid", 32'(bus.spawn_valid), 0);
        run = 1'b1;
        repeat (2) @(negedge clk);
        check("t5 reentry cleared", 32'(game_time), 0);
        do_ticks(2);
        check("t5 reentry counting", 32'(game_time), 2);

        // Asynchronous reset between clock edges while a spawn is pending
        start_level(7'b1000000, 1'b0);
        do_ticks(20);
        check("t6 pre valid", 32'(bus.spawn_valid), 1);
        check("t6 pre drop", 32'(drop_cnt), 1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6 async game_time", 32'(game_time), 0);
        check("t6 async valid", 32'(bus.spawn_valid), 0);
        check("t6 async kind", 32'(bus.spawn_kind), 0);
        check("t6 async slot", 32'(bus.spawn_slot), 0);
        check("t6 async active", 32'(active_count), 0);
        check("t6 async drop", 32'(drop_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
